// File: rtl/qrisc32_mem_stage.sv
// qrisc32 MEM stage: data-bus loads/stores, stall generation, WB forwarding.
// Optional: QRISC32_DBUS_TIMEOUT_EN enables the access timeout and sticky bus_err.
package risc_pack;
  typedef struct packed {
    logic [4:0]  rd;
    logic        reg_write;
    logic        read_mem;
    logic        write_mem;
    logic [31:0] val_r1;
    logic [31:0] val_dst;
  } pipe_struct_t;
endpackage

module qrisc32_mem_stage
  import risc_pack::*;
#(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic         clk,
  input  logic         areset,
  input  pipe_struct_t pipe_mem_in,
  output pipe_struct_t pipe_mem_out,
  output logic         pipe_stall,
  output logic         dbus_req,
  output logic         dbus_we,
  output logic [31:0]  dbus_addr,
  output logic [31:0]  dbus_wdata,
  input  logic [31:0]  dbus_rdata,
  input  logic         dbus_ack,
  output logic         bus_err
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 2..255");
  end

  logic [0:0]   state;
  logic         mem_op;
  logic         done;
  logic         abort;
  pipe_struct_t fwd;

  assign mem_op = pipe_mem_in.read_mem | pipe_mem_in.write_mem;
  assign done   = (state == ACCESS) & dbus_ack;

`ifdef QRISC32_DBUS_TIMEOUT_EN
  logic [7:0] cnt;
  logic       err_q;

  assign abort   = (state == ACCESS) & ~dbus_ack
                 & (cnt == 8'(TIMEOUT_CYCLES - 1));
  assign bus_err = err_q;

  // Timeout counter and sticky error flag
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE)
        cnt <= '0;
      else if (!dbus_ack && !abort)
        cnt <= cnt + 8'd1;
      if (abort)
        err_q <= 1'b1;
    end
  end
`else
  assign abort   = 1'b0;
  assign bus_err = 1'b0;
`endif

  // Stall while an access is outstanding, release on completion/abort
  assign pipe_stall = mem_op & ~(done | abort);

  // Forwarded bundle: loads take bus data, or the error word on abort
  always_comb begin
    fwd = pipe_mem_in;
    if (state == ACCESS && !dbus_we)
      fwd.val_dst = dbus_ack ? dbus_rdata : ERR_RDATA;
  end

  // Access FSM, bus request registers and WB output register
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state        <= IDLE;
      dbus_req     <= 1'b0;
      dbus_we      <= 1'b0;
      dbus_addr    <= '0;
      dbus_wdata   <= '0;
      pipe_mem_out <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mem_op) begin
            dbus_req     <= 1'b1;
            dbus_we      <= pipe_mem_in.write_mem;
            dbus_addr    <= pipe_mem_in.val_r1;
            dbus_wdata   <= pipe_mem_in.val_dst;
            pipe_mem_out <= '0;
            state        <= ACCESS;
          end else begin
            pipe_mem_out <= pipe_mem_in;
          end
        end
        ACCESS: begin
          if (done || abort) begin
            pipe_mem_out <= fwd;
            dbus_req     <= 1'b0;
            dbus_we      <= 1'b0;
            state        <= IDLE;
          end else begin
            pipe_mem_out <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qrisc32_mem_stage.sv
// Directed testbench for qrisc32_mem_stage.
// Timeout scenario runs when QRISC32_DBUS_TIMEOUT_EN is defined.
module tb_qrisc32_mem_stage;
  import risc_pack::*;

  logic         clk = 1'b0;
  logic         areset;
  pipe_struct_t pin;
  pipe_struct_t pout;
  logic         pipe_stall;
  logic         dbus_req;
  logic         dbus_we;
  logic [31:0]  dbus_addr;
  logic [31:0]  dbus_wdata;
  logic [31:0]  dbus_rdata;
  logic         dbus_ack;
  logic         bus_err;

  int pass = 0;
  int total = 0;

  always #5 clk = ~clk;

  qrisc32_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk),
    .areset(areset),
    .pipe_mem_in(pin),
    .pipe_mem_out(pout),
    .pipe_stall(pipe_stall),
    .dbus_req(dbus_req),
    .dbus_we(dbus_we),
    .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata),
    .dbus_rdata(dbus_rdata),
    .dbus_ack(dbus_ack),
    .bus_err(bus_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic pipe_struct_t mk(logic rd_m, logic wr_m,
                                      logic [31:0] r1, logic [31:0] d);
    pipe_struct_t p;
    p = '0;
    p.rd = 5'd3;
    p.reg_write = rd_m;
    p.read_mem = rd_m;
    p.write_mem = wr_m;
    p.val_r1 = r1;
    p.val_dst = d;
    return p;
  endfunction

  task automatic test_reset();
    areset = 1'b1;
    pin = '0;
    dbus_ack = 1'b0;
    dbus_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({dbus_req, dbus_we, dbus_addr, dbus_wdata} !== 66'd0)
      $display("FAIL reset_bus got req=%0b addr=%h", dbus_req, dbus_addr);
    else pass++;
    total++;
    if (pout !== '0 || bus_err !== 1'b0)
      $display("FAIL reset_out got %h err=%0b exp 0", pout, bus_err);
    else pass++;
    areset = 1'b0;
    tick();
  endtask

  task automatic test_passthru();
    pin = mk(1'b0, 1'b0, 32'h0, 32'h1234);
    pin.reg_write = 1'b1;
    #1;
    total++;
    if (pipe_stall !== 1'b0 || dbus_req !== 1'b0)
      $display("FAIL t1_stall got stall=%0b req=%0b exp 0 0", pipe_stall, dbus_req);
    else pass++;
    tick();
    total++;
    if (pout.val_dst !== 32'h1234 || dbus_req !== 1'b0)
      $display("FAIL t1_out got %h req=%0b exp 1234 0", pout.val_dst, dbus_req);
    else pass++;
    pin = '0;
    tick();
  endtask

  task automatic test_load_wait();
    int req_cnt = 0;
    int stall_cnt = 0;
    pin = mk(1'b1, 1'b0, 32'h100, 32'h0);
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        dbus_ack = 1'b1;
        dbus_rdata = 32'hCAFE0001;
      end
      @(negedge clk);
      if (dbus_req) req_cnt++;
      if (pipe_stall) stall_cnt++;
      if (c >= 1) begin
        total++;
        if (dbus_addr !== 32'h100 || dbus_we !== 1'b0 || pout !== '0)
          $display("FAIL t2_acc%0d got addr=%h we=%0b out=%h", c, dbus_addr, dbus_we, pout);
        else pass++;
      end
      tick();
    end
    dbus_ack = 1'b0;
    dbus_rdata = '0;
    pin = '0;
    total++;
    if (req_cnt != 3 || stall_cnt != 3)
      $display("FAIL t2_counts got req=%0d stall=%0d exp 3 3", req_cnt, stall_cnt);
    else pass++;
    total++;
    if (pout.val_dst !== 32'hCAFE0001 || dbus_req !== 1'b0)
      $display("FAIL t2_data got %h req=%0b exp cafe0001 0", pout.val_dst, dbus_req);
    else pass++;
    tick();
  endtask

  task automatic test_store();
    int stall_cnt = 0;
    pin = mk(1'b0, 1'b1, 32'h40, 32'h55AA);
    @(negedge clk);
    if (pipe_stall) stall_cnt++;
    tick();
    dbus_ack = 1'b1;
    dbus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    if (pipe_stall) stall_cnt++;
    total++;
    if (dbus_req !== 1'b1 || dbus_we !== 1'b1 || dbus_wdata !== 32'h55AA
        || dbus_addr !== 32'h40)
      $display("FAIL t3_bus got req=%0b we=%0b wd=%h a=%h", dbus_req, dbus_we, dbus_wdata, dbus_addr);
    else pass++;
    tick();
    dbus_ack = 1'b0;
    pin = '0;
    total++;
    if (stall_cnt != 1)
      $display("FAIL t3_stall got %0d cycles exp 1", stall_cnt);
    else pass++;
    total++;
    if (pout.val_dst !== 32'h55AA || pout.write_mem !== 1'b1)
      $display("FAIL t3_out got %h exp 55aa", pout.val_dst);
    else pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] pat;
    pat = '0;
    pin = mk(1'b1, 1'b0, 32'h200, 32'h0);
    @(negedge clk);
    pat[3] = dbus_req;
    tick();
    dbus_ack = 1'b1;
    dbus_rdata = 32'hA1;
    @(negedge clk);
    pat[2] = dbus_req;
    tick();
    dbus_ack = 1'b0;
    pin = mk(1'b1, 1'b0, 32'h204, 32'h0);
    @(negedge clk);
    pat[1] = dbus_req;
    total++;
    if (pout.val_dst !== 32'hA1)
      $display("FAIL t4_first got %h exp a1", pout.val_dst);
    else pass++;
    tick();
    dbus_ack = 1'b1;
    dbus_rdata = 32'hB2;
    @(negedge clk);
    pat[0] = dbus_req;
    total++;
    if (dbus_addr !== 32'h204)
      $display("FAIL t4_addr got %h exp 204", dbus_addr);
    else pass++;
    tick();
    dbus_ack = 1'b0;
    pin = '0;
    total++;
    if (pat !== 4'b0101)
      $display("FAIL t4_req_pattern got %b exp 0101", pat);
    else pass++;
    total++;
    if (pout.val_dst !== 32'hB2)
      $display("FAIL t4_second got %h exp b2", pout.val_dst);
    else pass++;
    tick();
  endtask

  task automatic test_reset_in_access();
    pin = mk(1'b1, 1'b0, 32'h300, 32'h0);
    tick();
    total++;
    if (dbus_req !== 1'b1)
      $display("FAIL t5_pre got req=%0b exp 1", dbus_req);
    else pass++;
    #2;
    areset = 1'b1;
    #1;
    total++;
    if (dbus_req !== 1'b0 || pout !== '0 || bus_err !== 1'b0 || pipe_stall !== 1'b1)
      $display("FAIL t5_reset got req=%0b out=%h err=%0b stall=%0b",
               dbus_req, pout, bus_err, pipe_stall);
    else pass++;
    pin = mk(1'b0, 1'b0, 32'h0, 32'h77);
    #1;
    areset = 1'b0;
    tick();
    dbus_ack = 1'b1;
    dbus_rdata = 32'hFFFF_0000;
    tick();
    dbus_ack = 1'b0;
    total++;
    if (pout.val_dst !== 32'h77 || dbus_req !== 1'b0 || pipe_stall !== 1'b0)
      $display("FAIL t5_ack_ignored got %h req=%0b exp 77 0", pout.val_dst, dbus_req);
    else pass++;
    pin = '0;
    tick();
  endtask

`ifdef QRISC32_DBUS_TIMEOUT_EN
  task automatic test_timeout();
    int req_cnt = 0;
    pin = mk(1'b1, 1'b0, 32'h400, 32'h0);
    tick();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (dbus_req) req_cnt++;
      if (c == 3) begin
        total++;
        if (pipe_stall !== 1'b0)
          $display("FAIL t6_abort_stall got %0b exp 0", pipe_stall);
        else pass++;
      end
      tick();
    end
    pin = '0;
    total++;
    if (req_cnt != 4 || dbus_req !== 1'b0)
      $display("FAIL t6_req got %0d cycles req=%0b exp 4 0", req_cnt, dbus_req);
    else pass++;
    total++;
    if (pout.val_dst !== 32'hDEADBEEF || bus_err !== 1'b1)
      $display("FAIL t6_err got %h err=%0b exp deadbeef 1", pout.val_dst, bus_err);
    else pass++;
    tick();
    pin = mk(1'b0, 1'b1, 32'h44, 32'h9);
    tick();
    dbus_ack = 1'b1;
    tick();
    dbus_ack = 1'b0;
    pin = '0;
    total++;
    if (bus_err !== 1'b1 || pout.val_dst !== 32'h9)
      $display("FAIL t6_sticky got err=%0b out=%h exp 1 9", bus_err, pout.val_dst);
    else pass++;
    tick();
  endtask
`else
  task automatic test_timeout();
    int req_cnt = 0;
    pin = mk(1'b1, 1'b0, 32'h400, 32'h0);
    tick();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (dbus_req && pipe_stall && !bus_err) req_cnt++;
      tick();
    end
    total++;
    if (req_cnt != 20)
      $display("FAIL t6_no_timeout got %0d cycles exp 20", req_cnt);
    else pass++;
    dbus_ack = 1'b1;
    dbus_rdata = 32'h5150;
    tick();
    dbus_ack = 1'b0;
    pin = '0;
    total++;
    if (pout.val_dst !== 32'h5150 || bus_err !== 1'b0)
      $display("FAIL t6_late_ack got %h err=%0b exp 5150 0", pout.val_dst, bus_err);
    else pass++;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_passthru();
    test_load_wait();
    test_store();
    test_back_to_back();
    test_reset_in_access();
    test_timeout();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/qrisc32_mem_stage.md
Name: qrisc32_mem_stage

Overview:
- Pipeline MEM stage. Consumes the EX-stage output struct, performs data-memory loads and stores over a req/ack data bus, and forwards the struct to WB.
- Generates pipe_stall back to EX/ID/IF while a memory access is outstanding. EX holds its output register stable during that time.
- Non-memory instructions pass through with one register stage.

Parameters:
- TIMEOUT_CYCLES, 16, max ACCESS cycles before abort (used only with QRISC32_DBUS_TIMEOUT_EN); range 2..255.
- ERR_RDATA, 32'hDEAD_BEEF, load value returned on timeout abort.

Ports:
- clk  input  1  clock.
- areset  input  1  reset, asynchronous, active-high.
- pipe_mem_in  input  risc_pack::pipe_struct_t  from EX. Fields used:
  - read_mem, write_mem: access type.
  - val_r1: byte address, already computed by EX.
  - val_dst: store data.
- pipe_mem_out  output  risc_pack::pipe_struct_t  to WB; val_dst carries load data.
- pipe_stall  output  1  combinational stall to EX/ID/IF.
- dbus_req  output  1  registered access request.
- dbus_we  output  1  1=write, 0=read; valid while dbus_req=1.
- dbus_addr  output  32  access address = val_r1, unmodified.
- dbus_wdata  output  32  store data = val_dst.
- dbus_rdata  input  32  read data; sampled only in the cycle dbus_ack=1.
- dbus_ack  input  1  one-cycle completion strobe.
- bus_err  output  1  sticky timeout flag.

Behaviour:
- Reset (async, any state): state=IDLE; dbus_req=0, dbus_we=0, dbus_addr=0, dbus_wdata=0; pipe_mem_out='0; bus_err=0; timeout counter=0. An in-flight access is abandoned with no completion.
- mem_op = pipe_mem_in.read_mem | pipe_mem_in.write_mem. If both bits are set, the access is a write.
- FSM states: IDLE, ACCESS.
- IDLE, mem_op=0:
  - pipe_stall=0.
  - On clk edge, pipe_mem_out<=pipe_mem_in.
  - Latency 1 cycle.
- IDLE, mem_op=1:
  - pipe_stall=1; pipe_mem_out<='0 (bubble).
  - On clk edge: dbus_req<=1, dbus_we<=write_mem, dbus_addr<=val_r1, dbus_wdata<=val_dst; go to ACCESS.
- ACCESS, dbus_ack=0:
  - pipe_stall=1; bubble to pipe_mem_out.
  - dbus_req/we/addr/wdata held stable.
- ACCESS, dbus_ack=1:
  - pipe_stall=0.
  - On edge: pipe_mem_out<=pipe_mem_in, with val_dst replaced by dbus_rdata for a read. A write leaves val_dst unchanged.
  - dbus_req<=0, dbus_we<=0; go to IDLE.
- Minimum mem-op occupancy is 2 cycles (ack in the first ACCESS cycle). Back-to-back mem ops are therefore separated by one IDLE cycle with dbus_req=0.
- pipe_stall = mem_op & ~(state==ACCESS & dbus_ack). Purely combinational from registered state, pipe_mem_in and dbus_ack; no other combinational path.
- dbus_ack while in IDLE is ignored. dbus_rdata is ignored on writes.
- pipe_mem_in is stable while pipe_stall=1; the block does not re-sample it during ACCESS.

Optional Feature:
- Macro QRISC32_DBUS_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - When counter==TIMEOUT_CYCLES-1 and dbus_ack=0, the access aborts at that edge:
    - dbus_req<=0; state<=IDLE; bus_err<=1 (sticky until areset).
    - pipe_mem_out<=pipe_mem_in, with val_dst=ERR_RDATA for reads.
    - pipe_stall=0 in that abort cycle.
  - Ack in the same cycle as the timeout wins: normal completion, bus_err unchanged.
- Undefined: no counter; bus_err tied 0; ACCESS waits for ack indefinitely.

Test Plan:
1. Non-mem op with val_dst=32'h1234, ack never asserted -> pipe_mem_out.val_dst=32'h1234 one cycle later; pipe_stall=0 and dbus_req=0 throughout.
2. Load, val_r1=32'h100, ack on 3rd ACCESS cycle with rdata=32'hCAFE0001 -> dbus_req high 3 cycles, addr=32'h100, we=0; pipe_stall high 3 cycles; pipe_mem_out.val_dst=32'hCAFE0001 after the ack edge; bubbles ('0) before it.
3. Store, val_r1=32'h40, val_dst=32'h55AA, immediate ack -> one ACCESS cycle with we=1, wdata=32'h55AA; pipe_stall=1 for exactly 1 cycle; pipe_mem_out.val_dst=32'h55AA.
4. Two back-to-back loads, each acked immediately -> dbus_req pattern 0,1,0,1; 4 cycles total; each result in order on pipe_mem_out.
5. areset pulsed during ACCESS before ack -> dbus_req=0, pipe_stall follows mem_op only, pipe_mem_out='0, bus_err=0 immediately; a later ack pulse is ignored.
6. With QRISC32_DBUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, load never acked -> req drops after 4 ACCESS cycles; val_dst=32'hDEADBEEF; bus_err=1 and stays 1 through the next successful access.
